// File: rtl/u409_buffer_sequencer_if.sv
// U409 buffer sequencer bundle: 68040 cycle
// control toward the block, buffer control out.
interface u409_buffer_sequencer_if;
  logic       TSn;
  logic       RnW;
  logic [1:0] SIZ;
  logic       LV_SPACE;
  logic       TAn;
  logic       TEAn;
  logic       BUFENn;
  logic       BUFDIR;
  logic       BUF_RDY;
  logic       BUS_TIMEOUT;

  modport master (
    output TSn, RnW, SIZ, LV_SPACE,
    output TAn, TEAn,
    input  BUFENn, BUFDIR,
    input  BUF_RDY, BUS_TIMEOUT
  );

  modport slave (
    input  TSn, RnW, SIZ, LV_SPACE,
    input  TAn, TEAn,
    output BUFENn, BUFDIR,
    output BUF_RDY, BUS_TIMEOUT
  );
endinterface

// File: rtl/u409_buffer_sequencer.sv
// LVTTL data buffer (U802/U803) sequencer:
// settle, beat count, turnaround, timeout.
module u409_buffer_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TURN_CYCLES   = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input logic CLK40,
  input logic RESETn,
  u409_buffer_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, SETTLE, ACTIVE, TTL, TURN
  } state_t;

  localparam logic [2:0] SET_LAST =
    3'(SETTLE_CYCLES - 1);
  localparam logic [2:0] TURN_LAST =
    3'(TURN_CYCLES - 1);
  localparam logic [7:0] TMO_LAST =
    8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [2:0] dly, dly_nx;
  logic [2:0] beat, beat_nx;
  logic [2:0] tgt, tgt_nx;
  logic [7:0] tmo, tmo_nx;
  logic       pend, pend_nx;
  logic       p_rnw, p_rnw_nx;
  logic       p_line, p_line_nx;
  logic       p_lv, p_lv_nx;
  logic       dir, dir_nx;
  logic       to_nx;
  logic       en_reg, rdy_reg, to_reg;

  logic ts, ta, tea, tmo_hit;
  logic launch, l_rnw, l_line, l_lv;

  assign ts      = ~bus.TSn;
  assign ta      = ~bus.TAn;
  assign tea     = ~bus.TEAn;
  assign tmo_hit = (tmo == TMO_LAST);

  assign bus.BUFENn      = en_reg;
  assign bus.BUFDIR      = dir;
  assign bus.BUF_RDY     = rdy_reg;
  assign bus.BUS_TIMEOUT = to_reg;

  always_comb begin
    state_nx  = state;
    dly_nx    = dly;
    beat_nx   = beat;
    tgt_nx    = tgt;
    tmo_nx    = (tmo == 8'hFF) ? tmo
                               : tmo + 8'd1;
    pend_nx   = pend;
    p_rnw_nx  = p_rnw;
    p_line_nx = p_line;
    p_lv_nx   = p_lv;
    dir_nx    = dir;
    to_nx     = 1'b0;
    launch    = 1'b0;
    l_rnw     = bus.RnW;
    l_line    = (bus.SIZ == 2'b11);
    l_lv      = bus.LV_SPACE;

    unique case (state)
      IDLE: begin
        if (ts) launch = 1'b1;
      end
      SETTLE: begin
        if (tmo_hit) begin
          to_nx    = 1'b1;
          state_nx = TURN;
          dly_nx   = '0;
        end else if (dly == SET_LAST) begin
          state_nx = ACTIVE;
          dly_nx   = '0;
        end else begin
          dly_nx = dly + 3'd1;
        end
      end
      ACTIVE: begin
        // error ack wins over a same-cycle TA
        if (tea) begin
          state_nx = TURN;
        end else if (ta &&
                     beat + 3'd1 == tgt) begin
          state_nx = TURN;
        end else if (tmo_hit) begin
          to_nx    = 1'b1;
          state_nx = TURN;
        end else if (ta) begin
          beat_nx = beat + 3'd1;
        end
        dly_nx = '0;
      end
      TTL: begin
        if (ta || tea) begin
          state_nx = IDLE;
        end else if (tmo_hit) begin
          to_nx    = 1'b1;
          state_nx = IDLE;
        end
      end
      TURN: begin
        if (dly == TURN_LAST) begin
          dly_nx = '0;
          if (pend) begin
            launch  = 1'b1;
            l_rnw   = p_rnw;
            l_line  = p_line;
            l_lv    = p_lv;
            pend_nx = 1'b0;
          end else if (ts) begin
            launch = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          dly_nx = dly + 3'd1;
          if (ts && !pend) begin
            pend_nx   = 1'b1;
            p_rnw_nx  = bus.RnW;
            p_line_nx = (bus.SIZ == 2'b11);
            p_lv_nx   = bus.LV_SPACE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // direction only moves while disabled
    if (launch) begin
      tmo_nx  = '0;
      beat_nx = '0;
      dly_nx  = '0;
      tgt_nx  = l_line ? 3'd4 : 3'd1;
      if (l_lv) begin
        state_nx = SETTLE;
        dir_nx   = l_rnw;
      end else begin
        state_nx = TTL;
      end
    end
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      dly     <= '0;
      beat    <= '0;
      tgt     <= 3'd1;
      tmo     <= '0;
      pend    <= 1'b0;
      p_rnw   <= 1'b1;
      p_line  <= 1'b0;
      p_lv    <= 1'b0;
      dir     <= 1'b1;
      en_reg  <= 1'b1;
      rdy_reg <= 1'b0;
      to_reg  <= 1'b0;
    end else begin
      state   <= state_nx;
      dly     <= dly_nx;
      beat    <= beat_nx;
      tgt     <= tgt_nx;
      tmo     <= tmo_nx;
      pend    <= pend_nx;
      p_rnw   <= p_rnw_nx;
      p_line  <= p_line_nx;
      p_lv    <= p_lv_nx;
      dir     <= dir_nx;
      en_reg  <= !(state_nx == SETTLE ||
                   state_nx == ACTIVE);
      rdy_reg <= (state_nx == ACTIVE);
      to_reg  <= to_nx;
    end
  end
endmodule

// File: tb/tb_u409_buffer_sequencer.sv
// Bench for u409_buffer_sequencer: vector table,
// corner sequences, random run vs. cycle model.
module tb_u409_buffer_sequencer;
  localparam int SETTLE = 1;
  localparam int TURN   = 2;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  u409_buffer_sequencer_if bus ();

  u409_buffer_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .TURN_CYCLES  (TURN),
    .TIMEOUT      (TMO)
  ) dut (
    .CLK40 (clk),
    .RESETn(rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // ---- reference model: phase + countdowns ----
  localparam int P_IDLE = 0;
  localparam int P_SET  = 1;
  localparam int P_ACT  = 2;
  localparam int P_TTL  = 3;
  localparam int P_TURN = 4;

  typedef struct {
    logic rnw;
    logic line;
    logic lv;
  } ts_t;

  ts_t  pend_q[$];
  int   m_ph, m_settle, m_beats;
  int   m_turn, m_age;
  logic m_dir, m_to;

  task automatic m_reset();
    m_ph = P_IDLE;
    m_dir = 1'b1;
    m_to = 1'b0;
    m_age = 0;
    pend_q.delete();
  endtask

  task automatic m_start(input logic rnw,
                         input logic line,
                         input logic lv);
    m_age = 0;
    if (lv) begin
      m_ph = P_SET;
      m_dir = rnw;
      m_settle = SETTLE;
      m_beats = line ? 4 : 1;
    end else begin
      m_ph = P_TTL;
    end
  endtask

  task automatic m_turn_go();
    m_ph = P_TURN;
    m_turn = TURN;
  endtask

  task automatic m_edge(input logic ts,
                        input logic rnw,
                        input logic [1:0] siz,
                        input logic lv,
                        input logic ta,
                        input logic tea);
    ts_t t;
    m_to = 1'b0;
    case (m_ph)
      P_IDLE:
        if (ts) m_start(rnw, siz == 2'b11, lv);
      P_SET: begin
        m_age++;
        if (m_age == TMO) begin
          m_to = 1'b1;
          m_turn_go();
        end else begin
          m_settle--;
          if (m_settle == 0) m_ph = P_ACT;
        end
      end
      P_ACT: begin
        m_age++;
        if (tea) m_turn_go();
        else if (ta && m_beats == 1) m_turn_go();
        else if (m_age == TMO) begin
          m_to = 1'b1;
          m_turn_go();
        end else if (ta) m_beats--;
      end
      P_TTL: begin
        m_age++;
        if (ta || tea) m_ph = P_IDLE;
        else if (m_age == TMO) begin
          m_to = 1'b1;
          m_ph = P_IDLE;
        end
      end
      default: begin
        m_turn--;
        if (m_turn == 0) begin
          if (pend_q.size() != 0) begin
            t = pend_q.pop_front();
            m_start(t.rnw, t.line, t.lv);
          end else if (ts) begin
            m_start(rnw, siz == 2'b11, lv);
          end else begin
            m_ph = P_IDLE;
          end
        end else if (ts &&
                     pend_q.size() == 0) begin
          t.rnw = rnw;
          t.line = (siz == 2'b11);
          t.lv = lv;
          pend_q.push_back(t);
        end
      end
    endcase
  endtask

  function automatic logic [3:0] m_exp();
    logic en;
    en = !(m_ph == P_SET || m_ph == P_ACT);
    return {en, m_dir, m_ph == P_ACT, m_to};
  endfunction

  // ---- drive / check helpers ----
  function automatic logic [3:0] cur();
    return {bus.BUFENn, bus.BUFDIR,
            bus.BUF_RDY, bus.BUS_TIMEOUT};
  endfunction

  task automatic chk(input string name,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got en/dir/rdy/to=%b expected %b",
               name, $time, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.TSn = 1'b1;
    bus.RnW = 1'b1;
    bus.SIZ = 2'b00;
    bus.LV_SPACE = 1'b0;
    bus.TAn = 1'b1;
    bus.TEAn = 1'b1;
  endtask

  task automatic step(input logic ts,
                      input logic rnw,
                      input logic [1:0] siz,
                      input logic lv,
                      input logic ta,
                      input logic tea);
    @(negedge clk);
    bus.TSn = !ts;
    bus.RnW = rnw;
    bus.SIZ = siz;
    bus.LV_SPACE = lv;
    bus.TAn = !ta;
    bus.TEAn = !tea;
    @(posedge clk);
    m_edge(ts, rnw, siz, lv, ta, tea);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    chk("reset_state", cur(), 4'b1100);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---- vector table ----
  typedef struct {
    logic ts, rnw;
    logic [1:0] siz;
    logic lv, ta, tea;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ts,
                     input logic rnw,
                     input logic lv,
                     input logic ta,
                     input logic tea,
                     input logic [3:0] e);
    vec_t v;
    v.ts = ts;
    v.rnw = rnw;
    v.siz = 2'b00;
    v.lv = lv;
    v.ta = ta;
    v.tea = tea;
    v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    drive_idle();
    // exp = {BUFENn, BUFDIR, BUF_RDY, BUS_TIMEOUT}
    add(1, 1, 1, 0, 0, 4'b0100);
    add(0, 0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 1, 0, 4'b1100);
    add(1, 0, 1, 0, 0, 4'b1100);
    add(0, 0, 0, 0, 0, 4'b0000);
    add(0, 0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 1, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);
    add(1, 1, 0, 0, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);
    add(0, 0, 0, 1, 0, 4'b1000);
    add(1, 1, 1, 0, 0, 4'b0100);
    add(0, 0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 0, 1, 4'b1100);
    add(0, 0, 0, 0, 0, 4'b1100);
    add(0, 0, 0, 0, 0, 4'b1100);
    add(1, 0, 1, 0, 0, 4'b0000);
    add(0, 0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 1, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);
    add(1, 1, 1, 0, 0, 4'b0100);
    add(0, 0, 0, 0, 0, 4'b0110);
    add(0, 0, 0, 1, 0, 4'b1100);
    add(1, 0, 1, 0, 0, 4'b1100);
    add(1, 1, 0, 0, 0, 4'b0000);
    add(0, 0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 1, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);
    add(0, 0, 0, 0, 0, 4'b1000);

    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].ts, tbl[i].rnw, tbl[i].siz,
           tbl[i].lv, tbl[i].ta, tbl[i].tea);
      chk($sformatf("vec%0d", i), cur(),
          tbl[i].exp);
    end

    // line write, four beats
    step(1, 0, 2'b11, 1, 0, 0);
    chk("line_ts", cur(), 4'b0000);
    idle();
    chk("line_rdy", cur(), 4'b0010);
    idle();
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 2'b00, 0, 1, 0);
      chk($sformatf("line_beat%0d", k), cur(),
          (k < 3) ? 4'b0010 : 4'b1000);
    end
    idle();
    idle();

    // no acknowledge: forced termination
    step(1, 1, 2'b00, 1, 0, 0);
    for (int k = 1; k <= TMO; k++) begin
      idle();
      chk($sformatf("tmo_k%0d", k), cur(),
          (k == TMO) ? 4'b1101 : 4'b0110);
    end
    idle();
    chk("tmo_pulse_len", cur(), 4'b1100);
    idle();
    step(1, 1, 2'b00, 1, 0, 0);
    chk("tmo_back_idle", cur(), 4'b0100);
    idle();
    step(0, 0, 2'b00, 0, 1, 0);
    idle();
    idle();

    // TEA mid-burst, then reset in SETTLE
    step(1, 1, 2'b11, 1, 0, 0);
    idle();
    step(0, 0, 2'b00, 0, 1, 0);
    chk("tea_b1", cur(), 4'b0110);
    step(0, 0, 2'b00, 0, 1, 0);
    chk("tea_b2", cur(), 4'b0110);
    step(0, 0, 2'b00, 0, 0, 1);
    chk("tea_turn", cur(), 4'b1100);
    idle();
    idle();
    step(1, 0, 2'b00, 1, 0, 0);
    chk("pre_reset", cur(), 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", cur(), 4'b1100);
    drive_idle();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic vs. model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic ts, rnw, lv, ta, tea;
      logic [1:0] siz;
      int tap;
      tap = (i < 1500) ? 3 : 24;
      ts  = ($urandom_range(3) == 0);
      rnw = 1'($urandom_range(1));
      siz = 2'($urandom_range(3));
      lv  = 1'($urandom_range(1));
      ta  = ($urandom_range(tap - 1) == 0);
      tea = ($urandom_range(15) == 0);
      step(ts, rnw, siz, lv, ta, tea);
      chk($sformatf("rand%0d", i), cur(),
          m_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
